// File: rtl/mul_seq_arbiter.sv
// Shared shift-add multiplier with a two-requester round-robin front end.
// One partial product is added per RUN cycle; the product is held on a
// valid/ready result port, tagged with the requester it belongs to.
//
// state | meaning
// IDLE  | waiting for operands; the granted requester sees ready
// RUN   | N shift-add steps, one multiplier bit per cycle
// DONE  | product presented; leaves when the consumer takes it
module mul_seq_arbiter #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res,
  output logic             res_tag,
  output logic             busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tag_q, tag_d;
  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
  logic             last_q, last_d;
  logic [2*N-1:0]   res_q, res_d;
  logic             res_tag_q, res_tag_d;

  logic             grant0, grant1;
  logic [N-1:0]     addend;
  logic [N:0]       sum;

  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  // Next-state, datapath step and handshake outputs.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    last_d     = last_q;
    res_d      = res_q;
    res_tag_d  = res_tag_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    addend     = mq_q[0] ? mcand_q : '0;
    sum        = {1'b0, acc_q} + {1'b0, addend};

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        // a grant already implies the matching valid, so it is the handshake
        if (grant0 | grant1) begin
          mcand_d = grant1 ? req1_a : req0_a;
          mq_d    = grant1 ? req1_b : req0_b;
          acc_d   = '0;
          cnt_d   = '0;
          tag_d   = grant1;
          last_d  = grant1;
          state_d = RUN;
        end
      end
      RUN: begin
        // carry of the add drops into the accumulator MSB, sum LSB into mq MSB
        acc_d = sum[N:1];
        mq_d  = (mq_q >> 1) | (N'(sum[0]) << (N - 1));
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          res_d     = {sum[N:1], mq_d};
          res_tag_d = tag_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, arbitration pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      tag_q     <= 1'b0;
      last_q    <= 1'b1;
      res_q     <= '0;
      res_tag_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      last_q    <= last_d;
      res_q     <= res_d;
      res_tag_q <= res_tag_d;
    end
  end

  assign res       = res_q;
  assign res_tag   = res_tag_q;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: an N=8 instance checked every cycle against a
// transaction-level model (countdown + a*b), plus an N=1 instance driven
// with directed vectors.
module tb_mul_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, r0, r1, rv, rr, rtag, busy;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] res;

  logic        n1_v0, n1_v1, n1_r0, n1_r1, n1_rv, n1_rr, n1_tag, n1_busy;
  logic        n1_a0, n1_b0, n1_a1, n1_b1;
  logic [1:0]  n1_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_seq_arbiter #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .res_valid(rv), .res_ready(rr), .res(res), .res_tag(rtag), .busy(busy)
  );

  mul_seq_arbiter #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n1_v0), .req0_ready(n1_r0), .req0_a(n1_a0), .req0_b(n1_b0),
    .req1_valid(n1_v1), .req1_ready(n1_r1), .req1_a(n1_a1), .req1_b(n1_b1),
    .res_valid(n1_rv), .res_ready(n1_rr), .res(n1_res), .res_tag(n1_tag),
    .busy(n1_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the N=8 instance -------------
  // m_left: -1 idle, >0 cycles of work remaining, 0 result on offer
  int          cyc = 0;
  int          m_left = -1;
  logic [15:0] m_prod = '0, m_res = '0;
  logic        m_tag = 1'b0, m_res_tag = 1'b0, m_last = 1'b1;
  int          rise_cyc = 0;
  bit          r0_seen = 0;
  int          hs_tag_q[$];
  int          hs_cyc_q[$];
  int          rs_val_q[$];
  int          rs_tag_q[$];
  int          rs_lat_q[$];

  always @(negedge clk) begin
    logic g0, g1;
    cyc++;
    if (!rst_n) begin
      m_left    = -1;
      m_res     = '0;
      m_res_tag = 1'b0;
      m_last    = 1'b1;
    end
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_left < 0) begin
      g0 = v0 && (!v1 || m_last);
      g1 = v1 && (!v0 || !m_last);
    end
    chk("ready0", r0, g0);
    chk("ready1", r1, g1);
    chk("res_valid", rv, m_left == 0);
    chk("busy", busy, m_left >= 0);
    chk("res", res, m_res);
    chk("res_tag", rtag, m_res_tag);
    if (r0) r0_seen = 1;
    if (rst_n) begin
      if (m_left < 0) begin
        if (g0 || g1) begin
          m_tag  = g1;
          m_last = g1;
          m_prod = g1 ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
          m_left = 8;
          hs_tag_q.push_back(int'(g1));
          hs_cyc_q.push_back(cyc);
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res     = m_prod;
          m_res_tag = m_tag;
          rise_cyc  = cyc + 1;
        end
      end else if (rr) begin
        rs_val_q.push_back(int'(m_res));
        rs_tag_q.push_back(int'(m_res_tag));
        rs_lat_q.push_back(rise_cyc - hs_cyc_q[hs_cyc_q.size()-1]);
        m_left = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int who, input logic [7:0] a, input logic [7:0] b);
    int n0;
    n0 = hs_tag_q.size();
    if (who == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
    else          begin v1 = 1'b1; a1 = a; b1 = b; end
    for (int i = 0; i < 60 && hs_tag_q.size() == n0; i++) begin
      @(posedge clk); #1;
    end
    chk("send_handshake", hs_tag_q.size() > n0, 1);
    if (who == 0) v0 = 1'b0;
    else          v1 = 1'b0;
  endtask

  task automatic wait_res(input int n);
    for (int i = 0; i < 200 && rs_val_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    chk("result_arrived", rs_val_q.size() >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int nb, nh;
    int lat;
    logic [1:0] kk;
    rst_n = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rr = 1'b1;
    n1_v0 = 0; n1_v1 = 0; n1_a0 = 0; n1_b0 = 0; n1_a1 = 0; n1_b1 = 0; n1_rr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", res, 0);
    chk("rst_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag", rtag, 0);
    chk("rst_n1_res", n1_res, 0);
    chk("rst_n1_busy", n1_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 255*255 from requester 0
    send(0, 8'd255, 8'd255);
    wait_res(1);
    chk("t1_res", rs_val_q[0], 32'hFE01);
    chk("t1_tag", rs_tag_q[0], 0);
    chk("t1_latency", rs_lat_q[0], 9);

    // requester 1 alone, zero multiplicand then 13*11
    r0_seen = 0;
    send(1, 8'd0, 8'd173);
    wait_res(2);
    send(1, 8'd13, 8'd11);
    wait_res(3);
    chk("t2_res0", rs_val_q[1], 0);
    chk("t2_tag0", rs_tag_q[1], 1);
    chk("t2_res1", rs_val_q[2], 143);
    chk("t2_tag1", rs_tag_q[2], 1);
    chk("t2_no_ready0", r0_seen, 0);

    // both valid from reset: strict alternation starting at requester 0
    nb = rs_val_q.size();
    nh = hs_tag_q.size();
    rst_n = 1'b0;
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9; v0 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_res(nb + 4);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", hs_tag_q[nh+i], i % 2);
      chk("t3_res", rs_val_q[nb+i], (i % 2 == 0) ? 15 : 63);
      chk("t3_tag", rs_tag_q[nb+i], i % 2);
    end

    // back-pressure on the result port
    rr = 1'b0;
    send(0, 8'd200, 8'd100);
    for (int i = 0; i < 40 && !rv; i++) begin
      @(posedge clk); #1;
    end
    chk("t4_valid_up", rv, 1);
    a0 = 8'd1; b0 = 8'd1; a1 = 8'd1; b1 = 8'd1; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", rv, 1);
      chk("t4_hold_res", res, 20000);
      chk("t4_hold_r0", r0, 0);
      chk("t4_hold_r1", r1, 0);
    end
    rr = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    chk("t4_drained", rv, 0);
    chk("t4_idle", busy, 0);
    chk("t4_res_kept", res, 20000);

    // reset in the 4th RUN cycle discards the operation
    nb = rs_val_q.size();
    send(0, 8'd99, 8'd77);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_running", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_res", res, 0);
    chk("t5_rst_valid", rv, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tag", rtag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("t5_no_result", rs_val_q.size(), nb);
    send(1, 8'd2, 8'd3);
    wait_res(nb + 1);
    chk("t5_res", rs_val_q[nb], 6);
    chk("t5_tag", rs_tag_q[nb], 1);
    nh = hs_tag_q.size();
    a0 = 8'd4; b0 = 8'd5; a1 = 8'd6; b1 = 8'd7; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 20 && hs_tag_q.size() == nh; i++) begin
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("t5_tie_handshake", hs_tag_q.size() > nh, 1);
    wait_res(nb + 2);
    chk("t5_tie_grant", hs_tag_q[nh], 0);
    chk("t5_tie_res", rs_val_q[nb+1], 20);

    // N=1 instance: all four operand combinations
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      n1_a0 = kk[1];
      n1_b0 = kk[0];
      n1_v0 = 1'b1;
      @(negedge clk);
      chk("n1_ready", n1_r0, 1);
      @(posedge clk); #1;
      n1_v0 = 1'b0;
      lat = 0;
      for (int i = 0; i < 10 && !n1_rv; i++) begin
        @(negedge clk);
        lat++;
      end
      chk("n1_latency", lat, 2);
      chk("n1_res", n1_res, {1'b0, kk[1] & kk[0]});
      chk("n1_tag", n1_tag, 0);
      @(posedge clk); #1;
      chk("n1_idle", n1_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_arbiter.md
Name: mul_seq_arbiter

Overview:
- Shared sequential shift-add multiplier engine with a 2-requester round-robin front end.
- Replaces duplicated combinational N-bit array multipliers where throughput is not critical: two clients time-share one N-bit adder datapath, one partial product per cycle.
- Result is returned on a single valid/ready output port, tagged with the originating requester.

Parameters:
- N, default 8, operand width in bits (N >= 1); product width is 2*N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  N  requester 0 multiplicand (unsigned).
- req0_b  input  N  requester 0 multiplier (unsigned).
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a  input  N  requester 1 multiplicand.
- req1_b  input  N  requester 1 multiplier.
- res_valid  output  1  product available.
- res_ready  input  1  consumer accepts product.
- res  output  2*N  unsigned product a*b.
- res_tag  output  1  requester index of current product.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; res=0; res_valid=0; res_tag=0; busy=0.
  - Round-robin pointer favours requester 0; internal accumulator, multiplier register and counter cleared.
  - Takes effect immediately, including mid-RUN or in DONE: the in-flight operation is discarded, no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - reqX_ready is combinational: reqX_ready = (state==IDLE) & grantX; at most one ready high per cycle.
  - Grant rule:
    - only one valid -> grant it;
    - both valid -> grant the requester not granted most recently (after reset: requester 0);
    - none valid -> no grant, stay IDLE.
  - On handshake (reqX_valid & reqX_ready):
    - load multiplicand=a, mq=b, acc=0 ((N+1) bits incl. carry), count=0;
    - tag=X, last_grant=X;
    - -> RUN.
- RUN: each cycle
  - sum = acc[N-1:0] + (mq[0] ? multiplicand : 0), an (N+1)-bit result;
  - {acc[N-1:0], mq} <= {sum, mq} >> 1, i.e. the carry enters the MSB;
  - count++;
  - after exactly N RUN cycles -> DONE, with product = {acc[N-1:0], mq}.
- DONE:
  - res_valid=1; res and res_tag are registered and stable while res_valid=1 && res_ready=0.
  - On res_valid & res_ready: res_valid drops next cycle -> IDLE.
  - No new operand is accepted in the same cycle as result drain.
- Latency: handshake at edge t -> res_valid=1 at edge t+N+1.
  - Minimum issue interval N+2 cycles (accept, N RUN, DONE drain with res_ready=1).
- res holds its last value after drain until the next DONE; this is not cleared.
- A request input changing while not ready is ignored; operands are sampled only at the handshake.
- N=1: single RUN cycle; product = a&b in bit 0, bit 1 = 0.
- Counter width clog2(N+1); no wrap occurs since it is cleared on each load.
- Arithmetic is unsigned only; no overflow is possible (2*N-bit result).

Test Plan:
- N=8; req0 a=255 b=255, res_ready=1 -> res=16'hFE01, res_tag=0, res_valid rises exactly 9 cycles after the handshake edge; busy high throughout.
- N=8; req1 a=0 b=173, then a=13 b=11 -> res=0 then res=143, both tag=1; req0_ready never asserted.
- N=8; req0 and req1 both valid continuously from reset (req0 a=3 b=5, req1 a=7 b=9) -> grants alternate 0,1,0,1; results 15,63,15,63 with matching tags.
- N=8; res_ready=0 for 20 cycles after DONE with a=200 b=100 -> res_valid stays 1, res=20000 stable, both readies 0; res_ready=1 -> drained, IDLE next cycle.
- N=8; rst_n pulsed low in 4th RUN cycle of a=99 b=77 -> outputs zero immediately; no result emitted; next request (req1 a=2 b=3) yields 6 with tag=1, and req0 wins if both valid.
- N=1; all four a,b combinations -> res = {1'b0, a&b}, latency 2 cycles.
